to_upper: RTL and testbench
===========================

# to_upper

Streaming ASCII case converter: accepts one 8-bit character per handshake, maps lowercase letters to uppercase and passes every other code unchanged. Output is registered, one character per cycle at full throughput. It sits in the text/character datapath between a byte source and any consumer that requires uppercase-normalised text. A saturating counter reports how many characters have been converted.

## Interface
- COUNT_W, 16, width of the converted-character counter.
- clk  input  1  sole clock; all state updates on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  8  input character code.
- in_valid  input  1  `a` is valid this cycle.
- in_ready  output  1  block accepts `a` this cycle.
- b  output  8  converted character.
- out_valid  output  1  `b` is valid.
- out_ready  input  1  consumer accepts `b` this cycle.
- out_conv  output  1  the character on `b` was changed by the mapping.
- conv_count  output  COUNT_W  number of converted characters accepted since reset; saturating.

## Operation
- Mapping, base: if 0x61 ≤ a ≤ 0x7A ('a'..'z'), then b = a − 0x20 and out_conv = 1. Otherwise b = a and out_conv = 0.
- Codes just outside the range pass unchanged: 0x60 '`', 0x7B '{', 0x40 '@', 0x5B '[', 0x7F DEL.
- Uppercase letters, digits, punctuation, control codes and all codes ≥ 0x80 pass unchanged, except where the Latin-1 option below applies.
- Input transfer occurs when in_valid && in_ready. Output transfer occurs when out_valid && out_ready.
- in_ready = !out_valid || out_ready. This is a single output register with no bubble.
- On an input transfer, the output register loads the mapped b and out_conv, and out_valid is set to 1.
- On an output transfer with no simultaneous input transfer, out_valid is cleared to 0.
- Simultaneous output and input transfers in the same cycle: the register reloads and out_valid stays 1.
- While out_valid = 1 and out_ready = 0, b and out_conv hold stable.
- conv_count increments by 1 on each input transfer whose mapped out_conv = 1. It holds at 2^COUNT_W − 1 once reached.

## Timing
- Reset (asynchronous assert, synchronous release): out_valid = 0, b = 0x00, out_conv = 0, conv_count = 0. Consequently in_ready = 1.
- Latency is 1 cycle: a character accepted at edge N is presented on b at edge N.
- Throughput is 1 character per cycle while out_ready = 1.
- in_ready is combinational from out_valid and out_ready. There is no combinational path from `a` to `b`.
- If reset asserts mid-stream, the held character is discarded and the counter is cleared.

## Configuration
- Macro TO_UPPER_LATIN1_EN.
- Defined: ISO-8859-1 lowercase letters are also converted. For codes 0xE0–0xFE, excluding 0xF7 '÷', b = a − 0x20 and out_conv = 1.
  - Examples: 0xEB 'ë' → 0xCB; 0xE0 → 0xC0; 0xFE → 0xDE.
  - Unchanged: 0xDF 'ß', 0xF7, 0xFF 'ÿ'.
- Undefined: all codes ≥ 0x80 pass unchanged with out_conv = 0.

## Structure
- Package to_upper_pkg holds:
  - CHAR_W = 8
  - LOWER_FIRST = 8'h61, LOWER_LAST = 8'h7A
  - CASE_DELTA = 8'h20
  - LATIN1_FIRST = 8'hE0, LATIN1_LAST = 8'hFE, LATIN1_SKIP = 8'hF7
- Sub-module to_upper_map: purely combinational, with a[7:0] in and b[7:0], conv out. The TO_UPPER_LATIN1_EN macro is evaluated only here.
- The top level holds the handshake register, the out_conv flag and the saturating counter.

## Test plan
- Reset, then stream with out_ready = 1: 0x28, 0x48, 0x61, 0x41, 0x7A, 0x6D, 0x30, 0x7B, 0x7F. Required b sequence, one cycle after each input: 0x28, 0x48, 0x41, 0x41, 0x5A, 0x4D, 0x30, 0x7B, 0x7F. out_conv = 1 only for the 3rd, 5th and 6th characters. conv_count = 3 at the end.
- Boundaries: 0x60 → 0x60, 0x7B → 0x7B, 0x40 → 0x40, 0x5B → 0x5B, 0x14 → 0x14.
- High codes 0xB7, 0x83, 0x92, 0xCF, 0x94 → unchanged in both builds. 0xEB → 0xEB without TO_UPPER_LATIN1_EN, 0xCB with it. 0xF7 and 0xFF → unchanged in both builds.
- Backpressure: hold out_ready = 0 after accepting 0x61.
  - b stays 0x41 and out_valid stays 1.
  - in_ready = 0, and the pending 0x62 is not accepted.
  - Raise out_ready: 0x42 follows on the next cycle with no loss or duplication.
- Assert rst_n low mid-stream while out_valid = 1. out_valid, b, out_conv and conv_count go to 0 immediately, without waiting for a clock edge.
- Saturation: with COUNT_W = 4, send 20 'a' characters. conv_count reaches 15 and holds.

Source files
------------

// File: rtl/to_upper_pkg.sv
// Shared constants and helpers for the to_upper character case converter.
// Build option: TO_UPPER_LATIN1_EN (consumed only by to_upper_map).
package to_upper_pkg;

    localparam int CHAR_W = 8;

    localparam logic [CHAR_W-1:0] LOWER_FIRST  = 8'h61;
    localparam logic [CHAR_W-1:0] LOWER_LAST   = 8'h7A;
    localparam logic [CHAR_W-1:0] CASE_DELTA   = 8'h20;
    localparam logic [CHAR_W-1:0] LATIN1_FIRST = 8'hE0;
    localparam logic [CHAR_W-1:0] LATIN1_LAST  = 8'hFE;
    localparam logic [CHAR_W-1:0] LATIN1_SKIP  = 8'hF7;

    // 'a'..'z'
    function automatic logic is_ascii_lower(input logic [CHAR_W-1:0] c);
        return (c >= LOWER_FIRST) && (c <= LOWER_LAST);
    endfunction

    // ISO-8859-1 lowercase letters; 0xF7 is the division sign, not a letter
    function automatic logic is_latin1_lower(input logic [CHAR_W-1:0] c);
        return (c >= LATIN1_FIRST) && (c <= LATIN1_LAST) && (c != LATIN1_SKIP);
    endfunction

endpackage

// File: rtl/to_upper_map.sv
// Combinational lowercase-to-uppercase mapping for one character.
// Build option: TO_UPPER_LATIN1_EN also folds ISO-8859-1 lowercase letters.
module to_upper_map
    import to_upper_pkg::*;
(
    input  logic [CHAR_W-1:0] a,
    output logic [CHAR_W-1:0] b,
    output logic              conv
);

    // Classify the code, then subtract the case offset when it is a lowercase letter
    always_comb begin
        conv = is_ascii_lower(a);
`ifdef TO_UPPER_LATIN1_EN
        conv = conv | is_latin1_lower(a);
`else
        conv = conv & ~a[CHAR_W-1];
`endif
        b = conv ? (a - CASE_DELTA) : a;
    end

endmodule

// File: rtl/to_upper.sv
// Streaming ASCII case converter: one registered output stage with a
// saturating count of converted characters.
// Build option: TO_UPPER_LATIN1_EN (see to_upper_map).
//
// Handshake: a transfer happens on a rising edge where valid && ready are both
// high. The producer holds its data stable while valid is high and ready is
// low; ready may depend combinationally on the consumer's ready, never on
// valid or data. Here in_ready = !out_valid || out_ready, so a single output
// register sustains one character per cycle with no bubble.
module to_upper
    import to_upper_pkg::*;
#(
    parameter int COUNT_W = 16
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [CHAR_W-1:0]  a,
    input  logic               in_valid,
    output logic               in_ready,
    output logic [CHAR_W-1:0]  b,
    output logic               out_valid,
    input  logic               out_ready,
    output logic               out_conv,
    output logic [COUNT_W-1:0] conv_count
);

    localparam logic [COUNT_W-1:0] COUNT_ONE = COUNT_W'(1);
    localparam logic [COUNT_W-1:0] COUNT_MAX = '1;

    logic [CHAR_W-1:0] map_b;
    logic              map_conv;
    logic              in_xfer;
    logic              out_xfer;

    to_upper_map u_map (
        .a    (a),
        .b    (map_b),
        .conv (map_conv)
    );

    // Ready whenever the output register is empty or being drained this cycle
    always_comb begin
        in_ready = !out_valid || out_ready;
        in_xfer  = in_valid && in_ready;
        out_xfer = out_valid && out_ready;
    end

    // Output register: load on input transfer, empty on a lone output transfer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            b         <= '0;
            out_conv  <= 1'b0;
            out_valid <= 1'b0;
        end else if (in_xfer) begin
            b         <= map_b;
            out_conv  <= map_conv;
            out_valid <= 1'b1;
        end else if (out_xfer) begin
            out_valid <= 1'b0;
        end
    end

    // Count accepted characters that were converted, sticking at all-ones
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            conv_count <= '0;
        end else if (in_xfer && map_conv && (conv_count != COUNT_MAX)) begin
            conv_count <= conv_count + COUNT_ONE;
        end
    end

endmodule

// File: tb/tb_to_upper.sv
// Directed testbench for to_upper: stream, boundary codes, high codes,
// backpressure, asynchronous reset mid-stream and counter saturation.
module tb_to_upper;

`ifdef TO_UPPER_LATIN1_EN
    localparam bit LAT = 1'b1;
`else
    localparam bit LAT = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  a;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  b;
    logic        out_valid;
    logic        out_ready;
    logic        out_conv;
    logic [15:0] conv_count;

    logic [7:0]  s_a;
    logic        s_in_valid;
    logic        s_in_ready;
    logic [7:0]  s_b;
    logic        s_out_valid;
    logic        s_out_conv;
    logic [3:0]  s_conv_count;

    logic [8:0]  exp_q[$];
    int          checks;
    int          errors;
    int          cyc;

    to_upper dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (a),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .b          (b),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_conv   (out_conv),
        .conv_count (conv_count)
    );

    to_upper #(.COUNT_W(4)) u_sat (
        .clk        (clk),
        .rst_n      (rst_n),
        .a          (s_a),
        .in_valid   (s_in_valid),
        .in_ready   (s_in_ready),
        .b          (s_b),
        .out_valid  (s_out_valid),
        .out_ready  (1'b1),
        .out_conv   (s_out_conv),
        .conv_count (s_conv_count)
    );

    // Clock and cycle counter
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    // Watchdog
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] want);
        checks++;
        if (obs !== want) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, want);
        end
    endtask

    // Scoreboard: every output transfer must match the oldest expected entry
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("sb_underflow", 32'(exp_q.size()), 32'd1);
            end else begin
                check("sb_data", {23'd0, out_conv, b}, {23'd0, exp_q.pop_front()});
            end
        end
    end

    // Present one character and wait (bounded) until it is accepted
    task automatic send(input logic [7:0] ch, input logic [7:0] eb, input logic ec);
        int budget;
        budget   = 0;
        a        = ch;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && budget < 20) begin
            @(negedge clk);
            budget++;
        end
        if (!in_ready) begin
            check("send_timeout", 32'd0, 32'd1);
            in_valid = 1'b0;
            return;
        end
        exp_q.push_back({ec, eb});
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic drain();
        out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("drain_q", 32'(exp_q.size()), 32'd0);
        check("drain_valid", {31'd0, out_valid}, 32'd0);
    endtask

    initial begin
        int c0;
        int base;
        checks     = 0;
        errors     = 0;
        cyc        = 0;
        rst_n      = 1'b0;
        a          = 8'h00;
        in_valid   = 1'b0;
        out_ready  = 1'b1;
        s_a        = 8'h00;
        s_in_valid = 1'b0;

        // Reset state
        #3;
        check("rst_valid", {31'd0, out_valid}, 32'd0);
        check("rst_b", {24'd0, b}, 32'h00);
        check("rst_conv", {31'd0, out_conv}, 32'd0);
        check("rst_count", {16'd0, conv_count}, 32'd0);
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Main stream at full throughput
        c0 = cyc;
        send(8'h28, 8'h28, 1'b0);
        send(8'h48, 8'h48, 1'b0);
        send(8'h61, 8'h41, 1'b1);
        send(8'h41, 8'h41, 1'b0);
        send(8'h7A, 8'h5A, 1'b1);
        send(8'h6D, 8'h4D, 1'b1);
        send(8'h30, 8'h30, 1'b0);
        send(8'h7B, 8'h7B, 1'b0);
        send(8'h7F, 8'h7F, 1'b0);
        check("stream_cycles", 32'(cyc - c0), 32'd9);
        check("stream_count", {16'd0, conv_count}, 32'd3);
        drain();

        // Codes just outside the lowercase range
        send(8'h60, 8'h60, 1'b0);
        send(8'h7B, 8'h7B, 1'b0);
        send(8'h40, 8'h40, 1'b0);
        send(8'h5B, 8'h5B, 1'b0);
        send(8'h14, 8'h14, 1'b0);
        drain();
        check("bound_count", {16'd0, conv_count}, 32'd3);

        // High codes, with and without the Latin-1 option
        send(8'hB7, 8'hB7, 1'b0);
        send(8'h83, 8'h83, 1'b0);
        send(8'h92, 8'h92, 1'b0);
        send(8'hCF, 8'hCF, 1'b0);
        send(8'h94, 8'h94, 1'b0);
        send(8'hEB, LAT ? 8'hCB : 8'hEB, LAT);
        send(8'hE0, LAT ? 8'hC0 : 8'hE0, LAT);
        send(8'hFE, LAT ? 8'hDE : 8'hFE, LAT);
        send(8'hF7, 8'hF7, 1'b0);
        send(8'hFF, 8'hFF, 1'b0);
        send(8'hDF, 8'hDF, 1'b0);
        drain();
        check("high_count", {16'd0, conv_count}, LAT ? 32'd6 : 32'd3);

        // Backpressure: hold the converted 'a', the next 'b' must wait
        base      = LAT ? 6 : 3;
        out_ready = 1'b0;
        send(8'h61, 8'h41, 1'b1);
        a        = 8'h62;
        in_valid = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("bp_b", {24'd0, b}, 32'h41);
            check("bp_valid", {31'd0, out_valid}, 32'd1);
            check("bp_conv", {31'd0, out_conv}, 32'd1);
            check("bp_in_ready", {31'd0, in_ready}, 32'd0);
            check("bp_count", {16'd0, conv_count}, 32'(base + 1));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        send(8'h62, 8'h42, 1'b1);
        drain();
        check("bp_count_end", {16'd0, conv_count}, 32'(base + 2));

        // Asynchronous reset while a character is held
        out_ready = 1'b0;
        send(8'h7A, 8'h5A, 1'b1);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", {31'd0, out_valid}, 32'd0);
        check("arst_b", {24'd0, b}, 32'h00);
        check("arst_conv", {31'd0, out_conv}, 32'd0);
        check("arst_count", {16'd0, conv_count}, 32'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        check("arst_in_ready", {31'd0, in_ready}, 32'd1);

        // Saturation with a 4-bit counter
        s_a        = 8'h61;
        s_in_valid = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            @(posedge clk);
            #1;
            if (i == 14) check("sat_count_14", {28'd0, s_conv_count}, 32'd14);
            if (i == 15) check("sat_count_15", {28'd0, s_conv_count}, 32'd15);
        end
        s_in_valid = 1'b0;
        check("sat_count_hold", {28'd0, s_conv_count}, 32'd15);
        check("sat_b", {24'd0, s_b}, 32'h41);

        // Main instance stayed idle and empty throughout
        check("final_q", 32'(exp_q.size()), 32'd0);
        check("final_count", {16'd0, conv_count}, 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
